// File: rtl/alu_arbiter2.sv
// Two-requester round-robin arbiter in front of a 4-bit ALU, one operation outstanding.
// Optional accepted-operation counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp0_valid,
  output logic [3:0] rsp0_result,
  output logic       rsp0_zero,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [3:0] rsp1_result,
  output logic       rsp1_zero,
  input  logic       rsp1_ready,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RESP = 1'b1;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    logic [3:0] res;
    case (op)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = a + b;
      3'b011:  res = a - b;
      3'b100:  res = ~a;
      default: res = 4'd0;
    endcase
    return res;
  endfunction

  logic       r_state;
  logic       w_state_nxt;
  logic       r_ptr;
  logic       r_owner;
  logic [3:0] r_result0;
  logic [3:0] r_result1;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_rsp_done;
  logic [3:0] w_alu0;
  logic [3:0] w_alu1;

  assign w_alu0 = alu_f(req0_a, req0_b, req0_op);
  assign w_alu1 = alu_f(req1_a, req1_b, req1_op);

  // Grant: a lone valid requester wins outright; a tie goes to the pointer.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant0 = req0_valid & (~req1_valid | (r_ptr == 1'b0));
      w_grant1 = req1_valid & (~req0_valid | (r_ptr == 1'b1));
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  // Only the owner's consume completes the response; the other rsp_ready is ignored.
  assign w_rsp_done = (r_owner == 1'b0) ? rsp0_ready : rsp1_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant0 | w_grant1) w_state_nxt = S_RESP;
        else                     w_state_nxt = S_IDLE;
      end
      S_RESP: begin
        if (w_rsp_done) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch result, owner and rotate pointer on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_result0 <= 4'd0;
      r_result1 <= 4'd0;
    end else if (w_grant0) begin
      r_ptr     <= 1'b1;
      r_owner   <= 1'b0;
      r_result0 <= w_alu0;
    end else if (w_grant1) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b1;
      r_result1 <= w_alu1;
    end else begin
      r_ptr     <= r_ptr;
      r_owner   <= r_owner;
      r_result0 <= r_result0;
      r_result1 <= r_result1;
    end
  end

  // Output logic.
  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    rsp0_valid = (r_state == S_RESP) & (r_owner == 1'b0);
    rsp1_valid = (r_state == S_RESP) & (r_owner == 1'b1);
  end

  assign rsp0_result = r_result0;
  assign rsp1_result = r_result1;
  assign rsp0_zero   = (r_result0 == 4'd0);
  assign rsp1_zero   = (r_result1 == 4'd0);

`ifdef ALU_ARB_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_grant0 && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
      else                               r_cnt0 <= r_cnt0;
      if (w_grant1 && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
      else                               r_cnt1 <= r_cnt1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

endmodule

// File: doc/alu_arbiter2.md
ALU_ARBITER2 -- requirements
Module: alu_arbiter2

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state updates on rising clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  operation from requester N accepted this cycle when reqN_valid also high.
REQ-006 reqN_a, reqN_b  input  4 each  operands from requester N.
REQ-007 reqN_op  input  3  opcode from requester N.
REQ-008 rspN_valid  output  1  result for requester N held on rspN_result/rspN_zero.
REQ-009 rspN_result  output  4  registered ALU result for requester N.
REQ-010 rspN_zero  output  1  high when rspN_result == 0.
REQ-011 rspN_ready  input  1  requester N consumes the response.
REQ-012 grant_cnt0, grant_cnt1  output  8 each  accepted-operation counters (see Configuration).

Function
REQ-013 Opcode map SHALL be: 000 a&b, 001 a|b, 010 a+b mod 16, 011 a-b mod 16, 100 ~a, 101-111 result 0.
REQ-014 zero SHALL be computed from the registered 4-bit result, so undefined opcodes give result 0, zero 1.
REQ-015 FSM states SHALL be IDLE and RESP; exactly one operation outstanding at any time.
REQ-016 In IDLE, at most one reqN_ready SHALL be high, and only for a requester with reqN_valid high.
REQ-017 Only one requester valid in IDLE: it SHALL be granted regardless of priority pointer.
REQ-018 Both valid in IDLE: requester named by priority pointer SHALL be granted.
REQ-019 On acceptance the pointer SHALL move to the non-granted requester (round-robin).
REQ-020 Acceptance (reqN_valid & reqN_ready in IDLE) SHALL latch operands/opcode-derived result and owner, and enter RESP next cycle.
REQ-021 Latency: rspN_valid SHALL rise exactly one cycle after the acceptance cycle.
REQ-022 In RESP, both reqN_ready SHALL be 0; only the owner's rspN_valid SHALL be 1.
REQ-023 rspN_result/rspN_zero SHALL stay stable while rspN_valid high and rspN_ready low.
REQ-024 Owner's rspN_ready high in RESP SHALL return FSM to IDLE next cycle; rspN_ready of non-owner SHALL be ignored.
REQ-025 Throughput SHALL be one operation per two cycles with rspN_ready held high.
REQ-026 reqN_ready SHALL be combinational from state, pointer and both reqN_valid; not from rspN_ready.
REQ-027 Operand/opcode changes while not accepted SHALL have no effect on state or outputs.
REQ-028 rspN_result SHALL hold last value when not valid; only rspN_valid qualifies it.

Reset
REQ-029 rst SHALL force: state IDLE, pointer to requester 0, rsp0_valid/rsp1_valid 0, rsp results 0, rsp zero 1, counters 0.
REQ-030 rst asserted in RESP SHALL discard the pending result; rspN_valid 0 from the next cycle; no handshake completes.
REQ-031 rst SHALL take priority over a simultaneous acceptance or response handshake.

Configuration
REQ-032 Macro ALU_ARB_STATS_EN: defined -> grant_cntN increments by 1 on each acceptance for requester N, saturating at 255.
REQ-033 ALU_ARB_STATS_EN undefined -> no counter registers; grant_cnt0/grant_cnt1 tied to 0; all other behaviour identical.

Verification
REQ-034 req0 valid alone, a=5 b=3 op=010, rsp0_ready=1 -> req0_ready same cycle, rsp0_valid next cycle, result 8, zero 0.
REQ-035 Both valid from reset, req0 SUB 3-3, req1 AND F&A -> req0 granted first (result 0, zero 1), req1 next (result A).
REQ-036 Both valid continuously, rsp ready high, 6 ops -> grants alternate 0,1,0,1,0,1; one rsp every two cycles.
REQ-037 req1 op=111 a=F, rsp1_ready low 4 cycles -> rsp1_valid held, result 0, zero 1 stable; no reqN_ready during hold.
REQ-038 rst pulsed in RESP with rsp0_valid high -> rsp0_valid 0 next cycle, pointer to 0, counters 0.
REQ-039 With ALU_ARB_STATS_EN, 300 req0 accepts -> grant_cnt0 = 255, grant_cnt1 = 0; without macro both remain 0.
